// File: rtl/blastit_pkg.sv
// Shared definitions for the seven-segment scan multiplexer.
//   - Digit entry layout: {en, sign, dp, val[3:0]}
//   - Hex segment table (bits 6:0 = g..a, active-high)
//   - Scan FSM state type
package blastit_pkg;

    localparam int ENTRY_W  = 7;
    localparam int EN_BIT   = 6;
    localparam int SIGN_BIT = 5;
    localparam int DP_BIT   = 4;
    localparam int VAL_W    = 4;

    // A sign-marked digit lights only segment g.
    localparam logic [6:0] SEG_MINUS = 7'h40;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_DWELL = 1'b1
    } scan_state_e;

    function automatic logic [6:0] hex_seg(input logic [VAL_W-1:0] v);
        return HEX_SEG[v];
    endfunction

endpackage

// File: rtl/sseg_decode.sv
// Combinational digit-entry to segment decoder.
// Ports:
//   entry : in  7-bit {en, sign, dp, val[3:0]}
//   seg   : out 8-bit segments, bit7 = dp, bits6:0 = g..a
// The en bit is not used here; gating is done by the scan logic.
module sseg_decode
    import blastit_pkg::*;
(
    input  logic [ENTRY_W-1:0] entry,
    output logic [7:0]         seg
);

    // Select minus-sign or hex glyph, then attach the decimal point.
    always_comb begin
        seg = 8'h00;
        if (entry[SIGN_BIT]) begin
            seg[6:0] = SEG_MINUS;
        end else begin
            seg[6:0] = hex_seg(entry[VAL_W-1:0]);
        end
        seg[7] = entry[DP_BIT];
    end

endmodule

// File: rtl/sseg_scan_mux.sv
// Multi-bank seven-segment scan multiplexer with per-bank PWM brightness.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   wr, wr_bank,
//   wr_digit, wr_val   : shadow digit write
//   bright_wr,
//   bright_bank,
//   bright_val         : per-bank brightness write (takes effect immediately)
//   dwell, blank       : on-phase / blank-phase length minus 1, in cycles
//   sseg               : registered segments (bit7 = dp)
//   oe                 : registered one-hot digit enable, bit = bank*DIGITS+digit
//   frame_tick         : one-cycle pulse when the scan wraps to index 0
// Digit writes land in a shadow file which is copied to the displayed
// (active) file on the wrap cycle, so a frame never shows a torn update.
module sseg_scan_mux
    import blastit_pkg::*;
#(
    parameter int BANKS      = 4,
    parameter int DIGITS     = 4,
    parameter int PWM_BITS   = 8,
    parameter int DWELL_BITS = 8,
    parameter int BLANK_BITS = 4
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    wr,
    input  logic [((BANKS > 1) ? $clog2(BANKS) : 1)-1:0]   wr_bank,
    input  logic [((DIGITS > 1) ? $clog2(DIGITS) : 1)-1:0] wr_digit,
    input  logic [ENTRY_W-1:0]                      wr_val,
    input  logic                                    bright_wr,
    input  logic [((BANKS > 1) ? $clog2(BANKS) : 1)-1:0]   bright_bank,
    input  logic [PWM_BITS-1:0]                     bright_val,
    input  logic [DWELL_BITS-1:0]                   dwell,
    input  logic [BLANK_BITS-1:0]                   blank,
    output logic [7:0]                              sseg,
    output logic [BANKS*DIGITS-1:0]                 oe,
    output logic                                    frame_tick
);

    localparam int NDIG   = BANKS * DIGITS;
    localparam int IDX_W  = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;
    localparam int CNT_W  = (DWELL_BITS > BLANK_BITS) ? DWELL_BITS : BLANK_BITS;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);

    logic [ENTRY_W-1:0]  shadow_r     [NDIG];
    logic [ENTRY_W-1:0]  active_r     [NDIG];
    logic [ENTRY_W-1:0]  shadow_nxt_s [NDIG];
    logic [PWM_BITS-1:0] bright_r     [BANKS];

    scan_state_e         state_r;
    logic [IDX_W-1:0]    index_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [CNT_W-1:0]    lim_r;
    logic [PWM_BITS-1:0] pwm_r;
    logic [7:0]          sseg_r;
    logic [NDIG-1:0]     oe_r;
    logic                frame_tick_r;

    logic [CNT_W-1:0]    limit_live_s;
    logic [CNT_W-1:0]    limit_s;
    logic                phase_done_s;
    logic                wrap_s;
    logic [BANK_W-1:0]   cur_bank_s;
    logic [ENTRY_W-1:0]  cur_entry_s;
    logic                pwm_on_s;
    logic                disp_s;
    logic [7:0]          seg_s;

    // Shadow file after this cycle's write; also the source of the wrap copy,
    // so a write on the wrap cycle is part of the new frame.
    always_comb begin
        for (int i = 0; i < NDIG; i++) begin
            if (wr && (int'(wr_bank) < BANKS) && (int'(wr_digit) < DIGITS) &&
                ((int'(wr_bank) * DIGITS + int'(wr_digit)) == i)) begin
                shadow_nxt_s[i] = wr_val;
            end else begin
                shadow_nxt_s[i] = shadow_r[i];
            end
        end
    end

    // Phase length is taken from the live input on the first cycle of a
    // phase and held in lim_r for the rest of it.
    always_comb begin
        if (state_r == ST_BLANK) begin
            limit_live_s = CNT_W'(blank);
        end else begin
            limit_live_s = CNT_W'(dwell);
        end
        if (cnt_r == {CNT_W{1'b0}}) begin
            limit_s = limit_live_s;
        end else begin
            limit_s = lim_r;
        end
        phase_done_s = (cnt_r == limit_s);
        wrap_s       = (state_r == ST_DWELL) && phase_done_s && (index_r == LAST_IDX);
    end

    // Current digit, its bank brightness and the display gate.
    always_comb begin
        cur_bank_s  = BANK_W'(int'(index_r) / DIGITS);
        cur_entry_s = active_r[index_r];
        pwm_on_s    = (pwm_r < bright_r[cur_bank_s]);
        disp_s      = (state_r == ST_DWELL) && cur_entry_s[EN_BIT] && pwm_on_s;
    end

    sseg_decode u_decode (
        .entry (cur_entry_s),
        .seg   (seg_s)
    );

    // Digit register files and brightness table.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NDIG; i++) begin
                shadow_r[i] <= {ENTRY_W{1'b0}};
                active_r[i] <= {ENTRY_W{1'b0}};
            end
            for (int b = 0; b < BANKS; b++) begin
                bright_r[b] <= {PWM_BITS{1'b0}};
            end
        end else begin
            for (int i = 0; i < NDIG; i++) begin
                shadow_r[i] <= shadow_nxt_s[i];
                if (wrap_s) begin
                    active_r[i] <= shadow_nxt_s[i];
                end
            end
            if (bright_wr && (int'(bright_bank) < BANKS)) begin
                bright_r[bright_bank] <= bright_val;
            end
        end
    end

    // Scan FSM, PWM counter and registered pin drivers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_BLANK;
            index_r      <= {IDX_W{1'b0}};
            cnt_r        <= {CNT_W{1'b0}};
            lim_r        <= {CNT_W{1'b0}};
            pwm_r        <= {PWM_BITS{1'b0}};
            sseg_r       <= 8'h00;
            oe_r         <= {NDIG{1'b0}};
            frame_tick_r <= 1'b0;
        end else begin
            pwm_r <= pwm_r + PWM_BITS'(1);
            if (cnt_r == {CNT_W{1'b0}}) begin
                lim_r <= limit_live_s;
            end
            if (phase_done_s) begin
                cnt_r <= {CNT_W{1'b0}};
                case (state_r)
                    ST_BLANK: state_r <= ST_DWELL;
                    ST_DWELL: begin
                        state_r <= ST_BLANK;
                        if (index_r == LAST_IDX) begin
                            index_r <= {IDX_W{1'b0}};
                        end else begin
                            index_r <= index_r + IDX_W'(1);
                        end
                    end
                    default: state_r <= ST_BLANK;
                endcase
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
            frame_tick_r <= wrap_s;
            if (disp_s) begin
                oe_r   <= {{(NDIG-1){1'b0}}, 1'b1} << index_r;
                sseg_r <= seg_s;
            end else begin
                oe_r   <= {NDIG{1'b0}};
                sseg_r <= 8'h00;
            end
        end
    end

    assign sseg       = sseg_r;
    assign oe         = oe_r;
    assign frame_tick = frame_tick_r;

endmodule

// File: tb/tb_sseg_scan_mux.sv
module tb_sseg_scan_mux;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr;
    logic [1:0]  wr_bank;
    logic [1:0]  wr_digit;
    logic [6:0]  wr_val;
    logic        bright_wr;
    logic [1:0]  bright_bank;
    logic [7:0]  bright_val;
    logic [7:0]  dwell;
    logic [3:0]  blank;
    logic [7:0]  sseg;
    logic [15:0] oe;
    logic        frame_tick;

    int checks_cnt = 0;
    int errors_cnt = 0;
    int n = 0;                 // active edges since reset release
    int ft_last = -1;
    int ft_prev = -1;
    bit cnt_en = 1'b0;
    int dut_b0 = 0;
    int dut_b2 = 0;
    int exp_b0 = 0;

    // Bench view of the design state, valid after edge n.
    logic [6:0] m_shadow [16];
    logic [6:0] m_active [16];
    logic [7:0] m_bright [4];

    sseg_scan_mux #(
        .BANKS(4), .DIGITS(4), .PWM_BITS(8), .DWELL_BITS(8), .BLANK_BITS(4)
    ) dut (
        .clk(clk), .reset(reset),
        .wr(wr), .wr_bank(wr_bank), .wr_digit(wr_digit), .wr_val(wr_val),
        .bright_wr(bright_wr), .bright_bank(bright_bank), .bright_val(bright_val),
        .dwell(dwell), .blank(blank),
        .sseg(sseg), .oe(oe), .frame_tick(frame_tick)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s at n=%0d: got=0x%0h expected=0x%0h", tag, n, got, exp);
        end
    endtask

    function automatic logic [7:0] seg_of(input logic [6:0] e);
        logic [6:0] s;
        if (e[5]) begin
            s = 7'h40;
        end else begin
            case (e[3:0])
                4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
                4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
                4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
                4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
            endcase
        end
        return {e[4], s};
    endfunction

    // One clock: sample after the edge, compare with expectations for the
    // scan position, then fold in the writes the DUT took at that edge.
    task automatic tick();
        int m, s, idx;
        bit on;
        logic [15:0] e_oe;
        logic [7:0]  e_seg;
        @(posedge clk);
        #1;
        if (reset) begin
            n = 0;
            for (int i = 0; i < 16; i++) begin
                m_shadow[i] = 7'h00;
                m_active[i] = 7'h00;
            end
            for (int b = 0; b < 4; b++) m_bright[b] = 8'h00;
            check_val("rst_oe", {16'h0, oe}, 32'h0);
            check_val("rst_sseg", {24'h0, sseg}, 32'h0);
            check_val("rst_ft", {31'h0, frame_tick}, 32'h0);
        end else begin
            n++;
            m   = n - 1;
            s   = m % 6;
            idx = (m / 6) % 16;
            on  = (s >= 2) && m_active[idx][6] && ((m % 256) < int'(m_bright[idx / 4]));
            e_oe  = on ? (16'h0001 << idx) : 16'h0000;
            e_seg = on ? seg_of(m_active[idx]) : 8'h00;
            check_val("oe", {16'h0, oe}, {16'h0, e_oe});
            check_val("sseg", {24'h0, sseg}, {24'h0, e_seg});
            check_val("frame_tick", {31'h0, frame_tick}, {31'h0, ((n % 96) == 0)});
            if (frame_tick) begin
                ft_prev = ft_last;
                ft_last = n;
            end
            if (cnt_en) begin
                if (oe[3:0] != 4'h0) dut_b0++;
                if (oe[11:8] != 4'h0) dut_b2++;
                if (e_oe[3:0] != 4'h0) exp_b0++;
            end
            if (wr) m_shadow[int'(wr_bank) * 4 + int'(wr_digit)] = wr_val;
            if (bright_wr) m_bright[bright_bank] = bright_val;
            if ((n % 96) == 0) begin
                for (int i = 0; i < 16; i++) m_active[i] = m_shadow[i];
            end
        end
    endtask

    task automatic run_to(input int target);
        while (n < target) tick();
    endtask

    task automatic do_wr(input logic [1:0] b, input logic [1:0] d, input logic [6:0] v);
        wr = 1'b1; wr_bank = b; wr_digit = d; wr_val = v;
        tick();
        wr = 1'b0;
    endtask

    task automatic do_br(input logic [1:0] b, input logic [7:0] v);
        bright_wr = 1'b1; bright_bank = b; bright_val = v;
        tick();
        bright_wr = 1'b0;
    endtask

    initial begin
        reset = 1'b1; wr = 1'b0; wr_bank = 2'd0; wr_digit = 2'd0; wr_val = 7'h00;
        bright_wr = 1'b0; bright_bank = 2'd0; bright_val = 8'h00;
        dwell = 8'd3; blank = 4'd1;

        // Reset, with a write attempt that must be ignored.
        tick();
        wr = 1'b1; wr_bank = 2'd0; wr_digit = 2'd2; wr_val = 7'h7F;
        tick();
        tick();
        wr = 1'b0;
        reset = 1'b0;

        // All digits enabled showing their own index, full brightness.
        for (int i = 0; i < 16; i++) do_wr(2'(i / 4), 2'(i % 4), 7'h40 | 7'(i));
        for (int b = 0; b < 4; b++) do_br(2'(b), 8'hFF);
        run_to(300);
        check_val("ft_period", ft_last - ft_prev, 32'd96);
        check_val("ft_last", ft_last, 32'd288);

        // Mid-frame write of bank1 digit2 = 8 with dp; shows only next frame.
        do_wr(2'd1, 2'd2, 7'h58);
        run_to(423);
        check_val("b1d2_oe", {16'h0, oe}, 32'h0040);
        check_val("b1d2_sseg", {24'h0, sseg}, 32'h00FF);

        // Minus sign on digit 0, digit 3 disabled.
        run_to(430);
        do_wr(2'd0, 2'd0, 7'h65);
        do_wr(2'd0, 2'd3, 7'h03);
        run_to(483);
        check_val("minus_oe", {16'h0, oe}, 32'h0001);
        check_val("minus_sseg", {24'h0, sseg}, 32'h0040);
        run_to(501);
        check_val("dis_slot_oe", {16'h0, oe}, 32'h0000);

        // Brightness: bank0 at quarter duty, bank2 off.
        run_to(576);
        do_br(2'd0, 8'd64);
        do_br(2'd2, 8'd0);
        run_to(579);
        cnt_en = 1'b1;
        run_to(1347);
        cnt_en = 1'b0;
        check_val("bank2_on", dut_b2, 32'd0);
        check_val("bank0_on", dut_b0, exp_b0);
        check_val("bank0_nonzero", {31'h0, (dut_b0 != 0)}, 32'd1);
        check_val("bank0_partial", {31'h0, (dut_b0 < 8 * 16)}, 32'd1);
        do_br(2'd0, 8'hFF);
        do_br(2'd2, 8'hFF);

        // Write landing exactly on the wrap edge appears in the next frame.
        run_to(1439);
        do_wr(2'd0, 2'd1, 7'h4A);
        run_to(1449);
        check_val("wrapwr_oe", {16'h0, oe}, 32'h0002);
        check_val("wrapwr_sseg", {24'h0, sseg}, 32'h0077);

        // Reset while a digit is lit; writes during reset are ignored.
        run_to(1450);
        reset = 1'b1;
        wr = 1'b1; wr_bank = 2'd0; wr_digit = 2'd2; wr_val = 7'h7F;
        tick();
        tick();
        wr = 1'b0;
        reset = 1'b0;
        do_br(2'd0, 8'hFF);
        do_wr(2'd0, 2'd0, 7'h41);
        run_to(99);
        check_val("post_rst_oe", {16'h0, oe}, 32'h0001);
        check_val("post_rst_sseg", {24'h0, sseg}, 32'h0006);
        run_to(200);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
